instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
Writer-side counterpart to the CPU's instruction-fetch read path. Receives a byte stream over a valid/ready handshake and packs it big-endian into 32-bit instruction words. Writes the words through the instruction memory write port at word-aligned byte addresses starting at 0. Holds the CPU in reset until a complete, checked image has been loaded.

Parameters:
ADDR_W, 7, word-address width; capacity is 2**ADDR_W words (default 128).
LEN_W, 16, width of the word-count header.

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous active-low reset
start_i  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
byte_valid_i  input  1  byte_data_i is valid this cycle
byte_data_i  input  8  stream byte
byte_ready_o  output  1  loader accepts a byte this cycle
mem_we_o  output  1  instruction memory write strobe, one-cycle pulse
mem_addr_o  output  32  byte address, word-aligned, bits[1:0] always 0
mem_wdata_o  output  32  instruction word
cpu_rst_n_o  output  1  active-low reset to the CPU; high only in DONE
busy_o  output  1  load in progress
done_o  output  1  last load succeeded
err_o  output  1  last load failed

Behaviour:
- Reset values (asynchronous): state IDLE; byte_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, cpu_rst_n_o=0, busy_o=0, done_o=0, err_o=0. All counters and the checksum clear.
- Handshake: a byte is accepted only on a cycle where byte_valid_i and byte_ready_o are both 1. byte_ready_o is 1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 in every other state. Back-to-back accepts are supported with no bubbles, including across word writes.
- Stream format: count N (LEN_W bits, MSB byte first), then 4*N payload bytes, then one checksum byte. The checksum is the XOR of all payload bytes; the header is excluded.
- States:
  - IDLE/DONE/ERR: start_i moves to LEN_HI and clears the counters, checksum, done_o and err_o. It also drives cpu_rst_n_o to 0.
  - LEN_HI: on accept, go to LEN_LO.
  - LEN_LO: on accept, go to DATA if 0 < N <= 2**ADDR_W; go to CSUM if N=0; go to ERR if N > 2**ADDR_W.
  - DATA: the first byte of each group of 4 goes to bits[31:24], the last to bits[7:0].
    - The cycle after the 4th accept of a group: mem_we_o=1, mem_wdata_o=packed word, mem_addr_o=word_idx*4. word_idx then increments.
    - After the N-th word's 4th byte, go to CSUM.
  - CSUM: on accept, go to DONE if the byte equals the running XOR, else ERR.
- Outputs by state:
  - busy_o=1 in LEN_HI through CSUM.
  - done_o=1 and cpu_rst_n_o=1 in DONE.
  - err_o=1 in ERR; cpu_rst_n_o stays 0.
- start_i while busy_o=1 is ignored.
- mem_we_o never asserts outside DATA/CSUM write slots.
- The final word's write pulse always occurs before or in the same cycle as the CSUM accept.
- Reset mid-load aborts immediately. A partially assembled word is never written.

Optional Feature:
IML_CSUM_EN.
- Defined: the checksum byte is expected and checked as above.
- Undefined: there is no CSUM state and no checksum logic.
  - The FSM goes from the final DATA write to DONE, entering DONE the cycle after the last payload byte is accepted (the same cycle as the final mem_we_o pulse).
  - N=0 goes directly to DONE.
  - Overflow still goes to ERR.

Decomposition:
- iml_pkg holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR);
  - the BYTES_PER_WORD=4 constant;
  - the default LEN_W.
- One sub-module, iml_word_packer: a 2-bit byte counter plus a 32-bit shift register. It outputs word_ready as a one-cycle pulse, and clears on a sync clear input.

Test Plan:
- Load N=1 with bytes 20 08 00 05 and checksum 2D → one mem_we_o pulse with addr 0x00000000 and data 0x20080005; then done_o=1 and cpu_rst_n_o=1.
- Load N=3 with words 0x20080005, 0x2009000A, 0x01095020 streamed with byte_valid_i held high → writes at 0x0, 0x4, 0x8 in that order; byte_ready_o never drops during DATA.
- Load N=1 (20 08 00 05) with checksum 00 → err_o=1, cpu_rst_n_o=0. A following start_i with a correct image → done_o=1.
- Header N=129 (0x0081) at ADDR_W=7 → ERR immediately after LEN_LO accept, with zero mem_we_o pulses.
- Random byte_valid_i gaps and a start_i pulse mid-DATA → data identical to the gap-free run; the mid-load start_i has no effect.
- Assert rst_i=0 after 2 of 4 payload bytes → all outputs at reset values, no write. Then a reload of N=0 with checksum 00 → DONE with no writes.

Source files
------------

// File: rtl/iml_pkg.sv
// Shared constants and FSM state encodings for the instruction memory loader.
package iml_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W_DEF      = 16;
  localparam int unsigned ST_W           = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEN_HI = 3'd1;
  localparam state_t ST_LEN_LO = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_CSUM   = 3'd4;
  localparam state_t ST_DONE   = 3'd5;
  localparam state_t ST_ERR    = 3'd6;

endpackage

// File: rtl/iml_word_packer.sv
// Packs accepted bytes big-endian into a 32-bit word and pulses word_ready_o
// the cycle after the fourth byte of a group.
module iml_word_packer
  import iml_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_c_o,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [1:0]  cnt_q;
  logic [23:0] sr_q;
  logic [31:0] word_q;
  logic        ready_q;

  assign last_byte_c_o = (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_o        = word_q;
  assign word_ready_o  = ready_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      sr_q    <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q   <= '0;
      sr_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= byte_en_i && last_byte_c_o;
      if (byte_en_i) begin
        cnt_q <= cnt_q + 2'd1;
        sr_q  <= {sr_q[15:0], byte_i};
        if (last_byte_c_o) word_q <= {sr_q, byte_i};
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed byte image into instruction memory and releases the
// CPU from reset once it is complete. Define IML_CSUM_EN for the trailing XOR checksum.
module instr_mem_loader
  import iml_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_rst_n_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned IDX_W    = ADDR_W + 1;
  localparam int unsigned CAPACITY = 1 << ADDR_W;
`ifdef IML_CSUM_EN
  localparam state_t ST_POST_DATA = ST_CSUM;
`else
  localparam state_t ST_POST_DATA = ST_DONE;
`endif

  state_t           state_q, state_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [LEN_W-1:0] n_q, n_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic [31:0]      addr_q, addr_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
`ifdef IML_CSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic accept_c, pk_clr_c, pk_en_c, pk_last_c, pk_ready;
  logic [31:0] pk_word;

  assign accept_c = byte_valid_i && ready_q;
  assign idx_inc  = idx_q + IDX_W'(1);

  iml_word_packer u_packer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clr_i         (pk_clr_c),
    .byte_en_i     (pk_en_c),
    .byte_i        (byte_data_i),
    .last_byte_c_o (pk_last_c),
    .word_o        (pk_word),
    .word_ready_o  (pk_ready)
  );

  // Next-state, datapath updates and registered output decode.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    n_d      = n_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    pk_clr_c = 1'b0;
    pk_en_c  = 1'b0;
`ifdef IML_CSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d  = ST_LEN_HI;
          len_hi_d = '0;
          n_d      = '0;
          idx_d    = '0;
          pk_clr_c = 1'b1;
`ifdef IML_CSUM_EN
          csum_d   = '0;
`endif
        end
      end
      ST_LEN_HI: begin
        if (accept_c) begin
          len_hi_d = byte_data_i;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept_c) begin
          n_d = LEN_W'({len_hi_q, byte_data_i});
          if (n_d == '0)                  state_d = ST_POST_DATA;
          else if (32'(n_d) > CAPACITY)   state_d = ST_ERR;
          else                            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept_c) begin
          pk_en_c = 1'b1;
`ifdef IML_CSUM_EN
          csum_d  = csum_q ^ byte_data_i;
`endif
          if (pk_last_c) begin
            addr_d = 32'({idx_q[ADDR_W-1:0], 2'b00});
            idx_d  = idx_inc;
            if (LEN_W'(idx_inc) == n_q) state_d = ST_POST_DATA;
          end
        end
      end
`ifdef IML_CSUM_EN
      ST_CSUM: begin
        if (accept_c) state_d = (byte_data_i == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
              (state_d == ST_DATA)   || (state_d == ST_CSUM);
    ready_d = busy_d;
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERR);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      len_hi_q <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef IML_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef IML_CSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign byte_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign cpu_rst_n_o  = done_q;
  assign err_o        = err_q;
  assign mem_we_o     = pk_ready;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = pk_word;

endmodule
